cache_fill_fsm: RTL and testbench

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

---
 rtl/cache_pkg.sv | 19 +
 rtl/cache_fill_fsm_wrap_counter.sv | 27 ++
 rtl/cache_fill_fsm.sv | 151 +++++++++++++++
 tb/tb_cache_fill_fsm.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache block-fill controller: block geometry,
// word-index width and the fill FSM state encoding.
package cache_pkg;

    // One cache block is eight 16-bit words (16 bytes).
    localparam int WORDS_PER_BLOCK   = 8;
    localparam int BLOCK_OFFSET_BITS = 4;
    localparam int WORD_IDX_BITS     = 3;

    // Index of the final word in a block, used to detect the end of a fill.
    localparam logic [WORD_IDX_BITS-1:0] LAST_WORD_IDX = WORD_IDX_BITS'(WORDS_PER_BLOCK - 1);

    // Fill controller states.
    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

endpackage : cache_pkg

// File: rtl/cache_fill_fsm_wrap_counter.sv
// Module wrap_counter: 3-bit word-offset counter with synchronous load and
// increment. The count wraps 7 -> 0, so a fill that starts mid-block walks
// through every word of the block exactly once.
module wrap_counter
    import cache_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [WORD_IDX_BITS-1:0] load_value,
    input  logic                     inc,
    output logic [WORD_IDX_BITS-1:0] count
);

    // Load wins over increment so a new fill always starts at its own offset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (inc) begin
            count <= count + WORD_IDX_BITS'(1);
        end
    end

endmodule : wrap_counter

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches one 16-byte cache block from a pipelined,
// fixed-latency memory after a miss. Eight word reads are issued on eight
// consecutive cycles; each returned word is written straight into the data
// array, and the tag/valid write is pulsed together with the eighth word.
//
// Build option: define FILL_CRITICAL_WORD_FIRST_EN to start the fill at the
// missing word (miss_address[3:1]) and wrap round the block; otherwise every
// fill starts at word 0.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    output logic                  fsm_busy,
    output logic                  mem_enable,
    output logic [ADDR_WIDTH-1:0] memory_address,
    input  logic                  mem_data_valid,
    input  logic [15:0]           mem_data,
    output logic                  write_data_array,
    output logic [2:0]            data_array_word,
    output logic [15:0]           data_array_data,
    output logic                  write_tag_array
);

    localparam int BLOCK_BITS = ADDR_WIDTH - BLOCK_OFFSET_BITS;

    // Terminal value of the issue/receive counts for this block size.
    localparam logic [WORD_IDX_BITS-1:0] LAST_CNT = WORD_IDX_BITS'(WORDS_PER_BLOCK - 1);

    fill_state_e              state;
    logic [BLOCK_BITS-1:0]    block_q;
    logic                     issue_active;
    logic [WORD_IDX_BITS-1:0] issue_cnt;
    logic [WORD_IDX_BITS-1:0] recv_cnt;
    logic [WORD_IDX_BITS-1:0] issue_off;
    logic [WORD_IDX_BITS-1:0] recv_off;
    logic [WORD_IDX_BITS-1:0] start_off;
    logic                     accept_miss;
    logic                     recv_word;
    logic                     recv_last;
    logic                     unused_offset_bits;

    // A miss is only taken while idle; requests during a fill are dropped.
    assign accept_miss = (state == IDLE) && miss_detected;

    // Returned words count only while filling, so stale returns after a
    // reset or stray strobes while idle never reach the data array.
    assign recv_word = (state == FILL) && mem_data_valid;
    assign recv_last = recv_word && (recv_cnt == LAST_CNT);

`ifdef FILL_CRITICAL_WORD_FIRST_EN
    assign start_off = miss_address[BLOCK_OFFSET_BITS-1:1];
`else
    assign start_off = '0;
`endif

    // Byte-offset bits are not needed in every build; fold them together so
    // the intentional non-use is explicit.
    assign unused_offset_bits = ^miss_address[BLOCK_OFFSET_BITS-1:0];

    // Offset of the word whose read is being issued this cycle.
    wrap_counter u_issue_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept_miss),
        .load_value (start_off),
        .inc        (issue_active),
        .count      (issue_off)
    );

    // Offset of the word that the next returned read belongs to.
    wrap_counter u_recv_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept_miss),
        .load_value (start_off),
        .inc        (recv_word),
        .count      (recv_off)
    );

    // Fill sequencing: latch the block, issue eight reads, retire after the
    // eighth returned word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            block_q      <= '0;
            issue_active <= 1'b0;
            issue_cnt    <= '0;
            recv_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_miss) begin
                        block_q      <= miss_address[ADDR_WIDTH-1:BLOCK_OFFSET_BITS];
                        issue_cnt    <= '0;
                        recv_cnt     <= '0;
                        issue_active <= 1'b1;
                        state        <= FILL;
                    end
                end
                FILL: begin
                    if (issue_active) begin
                        issue_cnt <= issue_cnt + WORD_IDX_BITS'(1);
                        if (issue_cnt == LAST_CNT) begin
                            issue_active <= 1'b0;
                        end
                    end
                    if (recv_word) begin
                        recv_cnt <= recv_cnt + WORD_IDX_BITS'(1);
                        if (recv_cnt == LAST_CNT) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output decode: everything is forced to zero outside a fill so the
    // memory and array interfaces stay quiet while idle or in reset.
    always_comb begin
        // NOTE: defaults first so no output path can infer a latch.
        fsm_busy         = 1'b0;
        mem_enable       = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        data_array_word  = '0;
        data_array_data  = '0;
        write_tag_array  = 1'b0;
        if (state == FILL) begin
            fsm_busy         = 1'b1;
            mem_enable       = issue_active;
            memory_address   = {block_q, issue_off, 1'b0};
            write_data_array = recv_word;
            data_array_word  = recv_off;
            write_tag_array  = recv_last;
            if (recv_word) begin
                data_array_data = mem_data;
            end
        end
    end

endmodule : cache_fill_fsm

// File: tb/tb_cache_fill_fsm.sv
// Directed testbench for cache_fill_fsm. A 4-cycle pipelined memory model
// answers each issued read with (address ^ 16'hC3C3). Expected behaviour per
// cycle after an accepted miss at cycle T: issues T+1..T+8, writes
// T+5..T+12, tag pulse at T+12, idle from T+13.
module tb_cache_fill_fsm;

    logic        clk;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        fsm_busy;
    logic        mem_enable;
    logic [15:0] memory_address;
    logic        mem_data_valid;
    logic [15:0] mem_data;
    logic        write_data_array;
    logic [2:0]  data_array_word;
    logic [15:0] data_array_data;
    logic        write_tag_array;

    int n_checks = 0;
    int n_fail   = 0;

    logic        pv [4];
    logic [15:0] pd [4];

    cache_fill_fsm #(
        .ADDR_WIDTH      (16),
        .WORDS_PER_BLOCK (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .fsm_busy         (fsm_busy),
        .mem_enable       (mem_enable),
        .memory_address   (memory_address),
        .mem_data_valid   (mem_data_valid),
        .mem_data         (mem_data),
        .write_data_array (write_data_array),
        .data_array_word  (data_array_word),
        .data_array_data  (data_array_data),
        .write_tag_array  (write_tag_array)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] start_of(input logic [15:0] a);
`ifdef FILL_CRITICAL_WORD_FIRST_EN
        return a[3:1];
`else
        return 3'd0;
`endif
    endfunction

    // Advance one cycle: capture the read issued in the ending cycle, then
    // drive the memory return that is due in the new cycle.
    task automatic next_cycle();
        logic        cap_v;
        logic [15:0] cap_d;
        @(negedge clk);
        cap_v = mem_enable;
        cap_d = memory_address ^ 16'hC3C3;
        @(posedge clk);
        #1;
        for (int i = 3; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = cap_v;
        pd[0] = cap_d;
        mem_data_valid = pv[3];
        mem_data       = pv[3] ? pd[3] : 16'h0;
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(fsm_busy), 32'd0);
        check({tag, "_en"},   32'(mem_enable), 32'd0);
        check({tag, "_addr"}, 32'(memory_address), 32'd0);
        check({tag, "_wr"},   32'(write_data_array), 32'd0);
        check({tag, "_word"}, 32'(data_array_word), 32'd0);
        check({tag, "_data"}, 32'(data_array_data), 32'd0);
        check({tag, "_tag"},  32'(write_tag_array), 32'd0);
    endtask

    // Request a miss in the current cycle (T) and check cycles T+1..T+13.
    // hold keeps miss_detected asserted; rst_at (>0) pulls reset in cycle T+rst_at.
    task automatic fill_check(input logic [15:0] a, input bit hold, input int rst_at);
        logic [2:0]  s;
        logic [2:0]  off;
        logic [15:0] exp_addr;
        bit          in_rst, e_busy, e_en, e_wr;
        s = start_of(a);
        miss_detected = 1'b1;
        miss_address  = a;
        #1;
        check("t0_busy", 32'(fsm_busy), 32'd0);
        for (int k = 1; k <= 13; k++) begin
            next_cycle();
            if (!hold) begin
                miss_detected = 1'b0;
                miss_address  = ~a;
            end
            if (rst_at != 0 && k == rst_at) begin
                rst_n = 1'b0;
                #1;
            end
            if (rst_at != 0 && k == rst_at + 1) begin
                rst_n = 1'b1;
                #1;
            end
            in_rst = (rst_at != 0) && (k >= rst_at);
            if (in_rst) begin
                check_all_zero("rst");
            end else begin
                e_busy = (k <= 12);
                e_en   = (k <= 8);
                e_wr   = (k >= 5) && (k <= 12);
                check("busy", 32'(fsm_busy), 32'(e_busy));
                check("en", 32'(mem_enable), 32'(e_en));
                if (e_en) begin
                    off = 3'(int'(s) + k - 1);
                    check("addr", 32'(memory_address), 32'({a[15:4], off, 1'b0}));
                end else if (!e_busy) begin
                    check("idle_addr", 32'(memory_address), 32'd0);
                end
                check("wr", 32'(write_data_array), 32'(e_wr));
                if (e_wr) begin
                    off      = 3'(int'(s) + k - 5);
                    exp_addr = {a[15:4], off, 1'b0};
                    check("word", 32'(data_array_word), 32'(off));
                    check("data", 32'(data_array_data), 32'(exp_addr ^ 16'hC3C3));
                end else if (!e_busy) begin
                    check("idle_word", 32'(data_array_word), 32'd0);
                end
                check("tag", 32'(write_tag_array), 32'(k == 12));
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        miss_detected  = 1'b0;
        miss_address   = 16'h0;
        mem_data_valid = 1'b0;
        mem_data       = 16'h0;
        for (int i = 0; i < 4; i++) begin
            pv[i] = 1'b0;
            pd[i] = 16'h0;
        end
        #1;
        check_all_zero("reset");
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        check_all_zero("post_reset");

        // Plain fill, sub-block address bits must be ignored for the block.
        fill_check(16'h1234, 1'b0, 0);
        next_cycle();

        // Mid-block miss: start offset depends on the build option.
        fill_check(16'h123A, 1'b0, 0);
        next_cycle();

        // Miss held through the fill: one fill, then a new one immediately.
        fill_check(16'h0040, 1'b1, 0);
        fill_check(16'h0040, 1'b0, 0);
        next_cycle();

        // Reset in the middle of a fill.
        fill_check(16'h2000, 1'b0, 7);
        next_cycle();
        check_all_zero("after_rst");

        // Stray return while idle.
        mem_data_valid = 1'b1;
        mem_data       = 16'hBEEF;
        #1;
        check("stray_wr", 32'(write_data_array), 32'd0);
        check("stray_tag", 32'(write_tag_array), 32'd0);
        check("stray_word", 32'(data_array_word), 32'd0);
        next_cycle();
        check("stray_busy", 32'(fsm_busy), 32'd0);

        // Back-to-back fills at both ends of the address space.
        fill_check(16'h0000, 1'b0, 0);
        fill_check(16'hFFF0, 1'b0, 0);
        next_cycle();
        check_all_zero("end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cache_fill_fsm
